decode_stage: RTL

- Registered, multi-lane decode stage between fetch and rename/dispatch in the OOO pipeline.
- Decodes DECODE_WIDTH instructions per cycle into register indices, sign-extended immediates and control bundles.
- Buffers decoded bundles in a BUF_DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Beyond a plain combinational decoder, it adds funct3/funct7 legality checking, x0-destination suppression, flush, and backpressure.

---
 rtl/decode_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Multi-lane decode stage: decodes one instruction bundle per cycle and buffers
// the decoded bundles in a small FIFO between fetch and rename/dispatch.
module decode_stage #(
    parameter int DECODE_WIDTH = 2,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DECODE_WIDTH-1:0]     in_lane_valid,
    input  logic [32*DECODE_WIDTH-1:0]  in_inst,
    input  logic [32*DECODE_WIDTH-1:0]  in_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DECODE_WIDTH-1:0]     out_lane_valid,
    output logic [32*DECODE_WIDTH-1:0]  out_pc,
    output logic [5*DECODE_WIDTH-1:0]   out_rs1,
    output logic [5*DECODE_WIDTH-1:0]   out_rs2,
    output logic [5*DECODE_WIDTH-1:0]   out_rd,
    output logic [32*DECODE_WIDTH-1:0]  out_imm,
    output logic [3*DECODE_WIDTH-1:0]   out_alu_op,
    output logic [DECODE_WIDTH-1:0]     out_alu_src,
    output logic [DECODE_WIDTH-1:0]     out_branch,
    output logic [DECODE_WIDTH-1:0]     out_jump,
    output logic [DECODE_WIDTH-1:0]     out_mem_read,
    output logic [DECODE_WIDTH-1:0]     out_mem_write,
    output logic [DECODE_WIDTH-1:0]     out_reg_write,
    output logic [DECODE_WIDTH-1:0]     out_mem_to_reg,
    output logic [DECODE_WIDTH-1:0]     out_illegal
);

    // Lane record, LSB first: illegal, mem_to_reg, reg_write, mem_write,
    // mem_read, jump, branch, alu_src, alu_op[3], imm[32], rd, rs2, rs1, pc, valid.
    localparam int LW = 91;
    localparam int BW = LW * DECODE_WIDTH;
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic [LW-1:0] decode_lane(input logic v, input logic [31:0] inst,
                                                  input logic [31:0] pc);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        legal;
        logic [2:0]  alu_op;
        logic [31:0] imm;
        logic        src, br, jmp, mr, mw, rw, mtr, ill;
        opc    = inst[6:0];
        f3     = inst[14:12];
        f7     = inst[31:25];
        legal  = 1'b0;
        alu_op = 3'b111;
        imm    = '0;
        src = 1'b0; br = 1'b0; jmp = 1'b0; mr = 1'b0;
        mw  = 1'b0; rw = 1'b0; mtr = 1'b0; ill = 1'b0;
        case (opc)
            OPC_LUI: begin
                legal = 1'b1; alu_op = 3'b100; rw = 1'b1;
                imm = {inst[31:12], 12'b0};
            end
            OPC_OPIMM: begin
                legal = f3 inside {3'b000, 3'b110, 3'b011};
                alu_op = 3'b010; src = 1'b1; rw = 1'b1;
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OP: begin
                legal = (f3 == 3'b000 && f7 == 7'b0100000) ||
                        (f3 == 3'b101 && f7 == 7'b0100000) ||
                        (f3 == 3'b111 && f7 == 7'b0000000);
                alu_op = 3'b001; rw = 1'b1;
            end
            OPC_LOAD: begin
                legal = f3 inside {3'b010, 3'b100};
                alu_op = 3'b000; src = 1'b1; mr = 1'b1; mtr = 1'b1; rw = 1'b1;
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                legal = f3 inside {3'b010, 3'b001};
                alu_op = 3'b000; src = 1'b1; mw = 1'b1;
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                legal = (f3 == 3'b001);
                alu_op = 3'b011; br = 1'b1;
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000);
                alu_op = 3'b101; src = 1'b1; jmp = 1'b1; rw = 1'b1;
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            alu_op = 3'b111; imm = '0;
            src = 1'b0; br = 1'b0; jmp = 1'b0; mr = 1'b0;
            mw  = 1'b0; rw = 1'b0; mtr = 1'b0; ill = 1'b1;
        end
        // Writes to x0 are architecturally dropped; the load itself still happens.
        if (inst[11:7] == 5'd0) begin
            rw = 1'b0; mtr = 1'b0;
        end
        if (!v) begin
            alu_op = 3'b000; imm = '0;
            src = 1'b0; br = 1'b0; jmp = 1'b0; mr = 1'b0;
            mw  = 1'b0; rw = 1'b0; mtr = 1'b0; ill = 1'b0;
        end
        return {v, pc, inst[19:15], inst[24:20], inst[11:7], imm, alu_op,
                src, br, jmp, mr, mw, rw, mtr, ill};
    endfunction

    logic [BW-1:0]  dec_bundle;
    logic [BW-1:0]  mem_q [BUF_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push, pop;
    logic [BW-1:0]  head;

    for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_dec
        assign dec_bundle[i*LW +: LW] = decode_lane(in_lane_valid[i], in_inst[32*i +: 32],
                                                    in_pc[32*i +: 32]);
    end

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < BUF_DEPTH; k++) mem_q[k] <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= dec_bundle;
        end
    end

    assign head = mem_q[rd_ptr_q];

    for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_out
        assign out_illegal[i]        = head[i*LW + 0];
        assign out_mem_to_reg[i]     = head[i*LW + 1];
        assign out_reg_write[i]      = head[i*LW + 2];
        assign out_mem_write[i]      = head[i*LW + 3];
        assign out_mem_read[i]       = head[i*LW + 4];
        assign out_jump[i]           = head[i*LW + 5];
        assign out_branch[i]         = head[i*LW + 6];
        assign out_alu_src[i]        = head[i*LW + 7];
        assign out_alu_op[3*i +: 3]  = head[i*LW + 8  +: 3];
        assign out_imm[32*i +: 32]   = head[i*LW + 11 +: 32];
        assign out_rd[5*i +: 5]      = head[i*LW + 43 +: 5];
        assign out_rs2[5*i +: 5]     = head[i*LW + 48 +: 5];
        assign out_rs1[5*i +: 5]     = head[i*LW + 53 +: 5];
        assign out_pc[32*i +: 32]    = head[i*LW + 58 +: 32];
        assign out_lane_valid[i]     = head[i*LW + 90];
    end

endmodule
